stopwatch_timer_core: RTL

- Parametrised successor to the fixed min:sec stopwatch counter. Counts BCD minutes:seconds directly, so no binary-to-BCD divide stage is needed.
- Adds:
  - configurable tick prescaler
  - up/down (countdown) mode
  - preset load
  - lap freeze
  - done indication
  - wrap/saturate option
- Sits between the ui_in button decode and the 7-segment driver; its bcd output feeds the driver's bcd input unchanged.

---
 rtl/stopwatch_timer_core.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core
// BCD minutes:seconds stopwatch/countdown timer with a tick prescaler,
// preset load, lap freeze, done indication and a wrap/saturate option.
// The bcd output drives the 7-segment driver's bcd input unchanged.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, stop, lap, load  control requests, acted on at their rising edge
//   mode                  0 = count up, 1 = count down (latched on entry to RUN)
//   preset[15:0]          BCD preset {min_tens, min_units, sec_tens, sec_units}
//   bcd[15:0]             displayed value, same packing as preset
//   running, lap_hold, done  status (RUN state, display frozen, DONE state)
//   tick                  one-cycle pulse in the cycle a count update is applied
//   state_dbg[1:0]        current FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
//
// All controls are level inputs that are already synchronous to clk; there
// is no valid/ready handshake on this block.
module stopwatch_timer_core #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 1,
    parameter int MAX_MIN = 59,
    parameter int WRAP    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        lap,
    input  logic        load,
    input  logic        mode,
    input  logic [15:0] preset,
    output logic [15:0] bcd,
    output logic        running,
    output logic        lap_hold,
    output logic        done,
    output logic        tick,
    output logic [1:0]  state_dbg
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [6:0]    MAX_MIN_B = 7'(MAX_MIN);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] presc_q, presc_n;
    logic [15:0]   count_q, count_n;
    logic [15:0]   lap_q, lap_n;
    logic          lap_hold_q, lap_hold_n;
    logic [15:0]   preset_q, preset_n;
    logic          mode_q, mode_n;
    logic [15:0]   bcd_q;
    logic          start_prev, stop_prev, lap_prev, load_prev;
    logic          start_e, stop_e, lap_e, load_e;
    logic          tick_c;

    logic [15:0]   up_next, down_next, preset_val, clear_val;
    logic          at_max_up, preset_ok;

    function automatic logic [6:0] min_bin(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    assign start_e = start & ~start_prev;
    assign stop_e  = stop  & ~stop_prev;
    assign lap_e   = lap   & ~lap_prev;
    assign load_e  = load  & ~load_prev;

    // BCD increment / decrement of the current count, digit by digit.
    always_comb begin
        up_next   = count_q;
        down_next = count_q;
        if (count_q[3:0] != 4'd9) begin
            up_next[3:0] = count_q[3:0] + 4'd1;
        end else begin
            up_next[3:0] = 4'd0;
            if (count_q[7:4] != 4'd5) begin
                up_next[7:4] = count_q[7:4] + 4'd1;
            end else begin
                up_next[7:4] = 4'd0;
                if (count_q[11:8] != 4'd9) begin
                    up_next[11:8] = count_q[11:8] + 4'd1;
                end else begin
                    up_next[11:8]  = 4'd0;
                    up_next[15:12] = count_q[15:12] + 4'd1;
                end
            end
        end
        if (count_q[3:0] != 4'd0) begin
            down_next[3:0] = count_q[3:0] - 4'd1;
        end else begin
            down_next[3:0] = 4'd9;
            if (count_q[7:4] != 4'd0) begin
                down_next[7:4] = count_q[7:4] - 4'd1;
            end else begin
                down_next[7:4] = 4'd5;
                if (count_q[11:8] != 4'd0) begin
                    down_next[11:8] = count_q[11:8] - 4'd1;
                end else begin
                    down_next[11:8]  = 4'd9;
                    down_next[15:12] = count_q[15:12] - 4'd1;
                end
            end
        end
    end

    assign at_max_up = (min_bin(count_q[15:12], count_q[11:8]) == MAX_MIN_B)
                       && (count_q[7:4] == 4'd5) && (count_q[3:0] == 4'd9);

    assign preset_ok = (preset[15:12] <= 4'd9) && (preset[11:8] <= 4'd9)
                       && (preset[7:4] <= 4'd5) && (preset[3:0] <= 4'd9)
                       && (min_bin(preset[15:12], preset[11:8]) <= MAX_MIN_B);
    assign preset_val = preset_ok ? preset : 16'h0000;

    // Leaving PAUSE/DONE through stop: countdowns restart from the preset.
    assign clear_val = mode_q ? preset_q : 16'h0000;

    always_comb begin
        state_n    = state_q;
        presc_n    = presc_q;
        count_n    = count_q;
        lap_n      = lap_q;
        lap_hold_n = lap_hold_q;
        preset_n   = preset_q;
        mode_n     = mode_q;
        tick_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_e) begin
                    preset_n = preset_val;
                    count_n  = preset_val;
                end else if (start_e && !(mode && count_q == 16'h0000)) begin
                    state_n = RUN;
                    mode_n  = mode;
                end
            end
            RUN: begin
                // A stop edge freezes the prescaler where it is, so a resume
                // finishes the partially elapsed tick period.
                if (stop_e) begin
                    state_n = PAUSE;
                end else begin
                    if (presc_q == PRESC_MAX) begin
                        presc_n = '0;
                        tick_c  = 1'b1;
                        if (!mode_q) begin
                            if (at_max_up) begin
                                if (WRAP != 0) count_n = 16'h0000;
                                else           state_n = DONE;
                            end else begin
                                count_n = up_next;
                            end
                        end else if (count_q == 16'h0000) begin
                            state_n = DONE;
                        end else begin
                            count_n = down_next;
                            if (down_next == 16'h0000) state_n = DONE;
                        end
                    end else begin
                        presc_n = presc_q + PW'(1);
                    end
                    if (lap_e) begin
                        if (lap_hold_q) begin
                            lap_hold_n = 1'b0;
                        end else begin
                            lap_hold_n = 1'b1;
                            lap_n      = count_q;
                        end
                    end
                end
            end
            PAUSE: begin
                if (load_e) begin
                    preset_n = preset_val;
                    count_n  = preset_val;
                    state_n  = IDLE;
                end else if (stop_e) begin
                    count_n = clear_val;
                    state_n = IDLE;
                end else if (start_e) begin
                    state_n = RUN;
                    mode_n  = mode;
                end else if (lap_e) begin
                    lap_hold_n = 1'b0;
                end
            end
            DONE: begin
                if (load_e) begin
                    preset_n = preset_val;
                    count_n  = preset_val;
                    state_n  = IDLE;
                end else if (stop_e) begin
                    count_n = clear_val;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE) presc_n = '0;
        if (state_n == IDLE || state_n == DONE) lap_hold_n = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            count_q    <= 16'h0000;
            lap_q      <= 16'h0000;
            lap_hold_q <= 1'b0;
            preset_q   <= 16'h0000;
            mode_q     <= 1'b0;
            bcd_q      <= 16'h0000;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            lap_prev   <= 1'b0;
            load_prev  <= 1'b0;
        end else begin
            state_q    <= state_n;
            presc_q    <= presc_n;
            count_q    <= count_n;
            lap_q      <= lap_n;
            lap_hold_q <= lap_hold_n;
            preset_q   <= preset_n;
            mode_q     <= mode_n;
            // Registered from next-state values so the display shows the
            // updated count in the cycle right after tick.
            bcd_q      <= lap_hold_n ? lap_n : count_n;
            start_prev <= start;
            stop_prev  <= stop;
            lap_prev   <= lap;
            load_prev  <= load;
        end
    end

    assign bcd       = bcd_q;
    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign lap_hold  = lap_hold_q;
    assign tick      = tick_c;
    assign state_dbg = state_q;

endmodule
